bmp_stream_writer: RTL and testbench
====================================

BMP_STREAM_WRITER -- requirements
Module: bmp_stream_writer

Interface
REQ-001 Parameter WIDTH, default 768, image width in pixels.
REQ-002 Parameter HEIGHT, default 576, image height in pixels.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to emit one frame; sampled only in IDLE.
REQ-006 pix_empty  input  1  pixel FIFO empty flag.
REQ-007 pix_dout  input  24  pixel FIFO head word; first-word-fall-through, valid while pix_empty=0.
REQ-008 pix_rd_en  output  1  pixel FIFO pop; combinational, asserted only when the head word is captured.
REQ-009 byte_out  output  8  registered output byte.
REQ-010 byte_valid  output  1  byte_out holds a valid byte.
REQ-011 byte_ready  input  1  downstream accepts; a transfer occurs on a rising edge with byte_valid=1 and byte_ready=1.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the final byte of a frame transfers.

Function
REQ-014 FSM states: IDLE, HDR, LOAD, PIX, PAD, DONE.
- IDLE->HDR on start (if BMP_HEADER_GEN_EN is defined), else IDLE->LOAD.
- HDR->LOAD after header byte 53 transfers.
- LOAD->PIX on capture.
- PIX->LOAD after byte 2 transfers while row pixels remain.
- PIX->PAD at end of row when PAD_BYTES>0.
- PIX or PAD->LOAD at end of row when rows remain.
- Final byte of final row->DONE.
- DONE->IDLE unconditionally.
REQ-015 While byte_valid=1 and byte_ready=0, byte_out and byte_valid are held stable and no counter advances.
REQ-016 Header byte sequence, multi-byte fields little-endian:
- 'B' 0x42, 'M' 0x4D
- file size = 54 + (WIDTH*3+PAD_BYTES)*HEIGHT (4 bytes)
- 0 (4 bytes)
- offset 54 (4 bytes)
- DIB size 40 (4 bytes)
- WIDTH (4 bytes)
- HEIGHT (4 bytes)
- planes 1 (2 bytes)
- bpp 24 (2 bytes)
- compression 0 (4 bytes)
- image size (WIDTH*3+PAD_BYTES)*HEIGHT (4 bytes)
- 2835 (4 bytes)
- 2835 (4 bytes)
- 0 (4 bytes)
- 0 (4 bytes)
REQ-017 Header bytes come from a 6-bit index 0..53; all header values are 32-bit constants computed from the parameters at elaboration.
REQ-018 In LOAD with pix_empty=0 and the output register free (byte_valid=0, or a transfer this cycle), the block asserts pix_rd_en for exactly one cycle, latches pix_dout into a 24-bit register, and loads byte_out=pix_dout[23:16] with byte_valid=1 on the next edge.
REQ-019 In LOAD with pix_empty=1, pix_rd_en=0 and byte_valid falls to 0 after any pending byte transfers; no bubble byte is emitted.
REQ-020 Pixel byte order is [23:16], [15:8], [7:0]; rows are emitted in FIFO arrival order with no reordering.
REQ-021 PAD_BYTES = (4 - (WIDTH*3)%4)%4; in PAD, PAD_BYTES bytes of 0x00 are emitted after each row, including the last.
REQ-022 Column counter spans 0..WIDTH-1 and wraps to 0 at row end; row counter spans 0..HEIGHT-1; both are sized $clog2 of their range.
REQ-023 With byte_ready held at 1 and the FIFO never empty, sustained throughput is one byte per cycle across header, pixel, pad and row boundaries.
REQ-024 start asserted while busy=1 is ignored.
REQ-025 done rises in the cycle after the last byte transfer; busy is still 1 in that cycle and 0 in the next.

Reset
REQ-026 Asserting reset, including mid-frame, forces:
- state IDLE
- byte_out=0x00, byte_valid=0, busy=0, done=0
- all counters and the pixel register cleared
REQ-027 pix_rd_en is 0 throughout reset; a partially emitted frame is abandoned and not resumed.

Configuration
REQ-028 With BMP_HEADER_GEN_EN defined, each frame begins with the 54 header bytes of REQ-016.
REQ-029 With BMP_HEADER_GEN_EN undefined, the HDR state and header logic are absent, and a frame is pixel and pad bytes only.

Verification
REQ-030 WIDTH=4, HEIGHT=2, macro on, start, byte_ready=1 -> bytes 42 4D 4E 00 00 00 ... with byte 18=0x04 and byte 22=0x02; 78 bytes total; done pulses once.
REQ-031 FIFO word 0xA1B2C3 -> pixel bytes A1, B2, C3 in order; one pix_rd_en pulse per pixel.
REQ-032 byte_ready toggled 1,0,0,1 -> byte_out stable across the low cycles; no byte lost or duplicated; a 78-byte compare passes.
REQ-033 pix_empty=1 for 5 cycles mid-row -> byte_valid=0 and pix_rd_en=0 during the stall; the stream resumes with the correct next pixel.
REQ-034 WIDTH=3, HEIGHT=2 -> 9 pixel bytes plus 3 bytes of 0x00 per row; file size 78.
REQ-035 reset asserted after byte 60 -> outputs cleared immediately; a new start emits a complete frame from 0x42.

Source files
------------

// File: rtl/bmp_stream_writer.sv
// Streams one 24-bit BMP frame per start request: optional 54-byte header, then FIFO pixels
// MSB-first with zero padding to a 4-byte row boundary. Header generation is built in with BMP_HEADER_GEN_EN.
module bmp_stream_writer #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        pix_empty,
  input  logic [23:0] pix_dout,
  output logic        pix_rd_en,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done
);

  localparam int PAD_BYTES = (4 - (WIDTH * 3) % 4) % 4;
  localparam int COL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [1:0]       PAD_LAST = 2'(PAD_BYTES - 1);

`ifdef BMP_HEADER_GEN_EN
  localparam logic [31:0] IMG_SIZE  = 32'((WIDTH * 3 + PAD_BYTES) * HEIGHT);
  localparam logic [31:0] FILE_SIZE = IMG_SIZE + 32'd54;

  // Byte 0 sits in the LSBs, so each 32-bit field lands little-endian without swapping.
  localparam logic [431:0] HDR_ROM = {
    32'd0, 32'd0, 32'd2835, 32'd2835, IMG_SIZE, 32'd0,
    16'd24, 16'd1, 32'(HEIGHT), 32'(WIDTH), 32'd40,
    32'd54, 32'd0, FILE_SIZE, 8'h4D, 8'h42
  };
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
`ifdef BMP_HEADER_GEN_EN
    HDR  = 3'd1,
`endif
    LOAD = 3'd2,
    PIX  = 3'd3,
    PAD  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t           state_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [1:0]       byte_idx_q;
  logic [1:0]       pad_q;
  logic             last_q;
  logic [23:0]      pix_q;
  logic [7:0]       byte_out_q;
  logic             byte_valid_q;
  logic             busy_q;
  logic             done_q;
`ifdef BMP_HEADER_GEN_EN
  logic [5:0]       hdr_idx_q;
`endif

  logic       xfer;
  logic       out_free;
  logic       col_last;
  logic       row_last;
  logic [7:0] pix_byte;

  // The output register may be reloaded when empty or when its byte leaves on this edge.
  assign xfer     = byte_valid_q & byte_ready;
  assign out_free = ~byte_valid_q | byte_ready;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  assign pix_rd_en  = (state_q == LOAD) & ~pix_empty & out_free;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // NOTE: every branch assigns pix_byte, so this stays combinational and infers no latch.
  always_comb begin
    case (byte_idx_q)
      2'd1:    pix_byte = pix_q[15:8];
      2'd2:    pix_byte = pix_q[7:0];
      default: pix_byte = pix_q[23:16];
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every branch reads pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      byte_idx_q   <= '0;
      pad_q        <= '0;
      last_q       <= 1'b0;
      pix_q        <= '0;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef BMP_HEADER_GEN_EN
      hdr_idx_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q     <= 1'b1;
            col_q      <= '0;
            row_q      <= '0;
            byte_idx_q <= '0;
            pad_q      <= '0;
            last_q     <= 1'b0;
`ifdef BMP_HEADER_GEN_EN
            hdr_idx_q  <= '0;
            state_q    <= HDR;
`else
            state_q    <= LOAD;
`endif
          end
        end

`ifdef BMP_HEADER_GEN_EN
        HDR: begin
          if (out_free) begin
            byte_out_q   <= HDR_ROM[{hdr_idx_q, 3'b000} +: 8];
            byte_valid_q <= 1'b1;
            if (hdr_idx_q == 6'd53) begin
              hdr_idx_q <= '0;
              state_q   <= LOAD;
            end else begin
              hdr_idx_q <= hdr_idx_q + 6'd1;
            end
          end
        end
`endif

        LOAD: begin
          if (pix_rd_en) begin
            pix_q        <= pix_dout;
            byte_out_q   <= pix_dout[23:16];
            byte_valid_q <= 1'b1;
            byte_idx_q   <= 2'd1;
            state_q      <= PIX;
          end else if (xfer) begin
            byte_valid_q <= 1'b0;
          end
        end

        PIX: begin
          // last_q means the frame's final byte is already loaded; wait for it to leave.
          if (last_q) begin
            if (xfer) begin
              byte_valid_q <= 1'b0;
              last_q       <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= DONE;
            end
          end else if (out_free) begin
            byte_out_q   <= pix_byte;
            byte_valid_q <= 1'b1;
            if (byte_idx_q == 2'd1) begin
              byte_idx_q <= 2'd2;
            end else begin
              byte_idx_q <= '0;
              if (!col_last) begin
                col_q   <= col_q + 1'b1;
                state_q <= LOAD;
              end else begin
                col_q <= '0;
                if (PAD_BYTES > 0) begin
                  state_q <= PAD;
                end else if (!row_last) begin
                  row_q   <= row_q + 1'b1;
                  state_q <= LOAD;
                end else begin
                  last_q <= 1'b1;
                end
              end
            end
          end
        end

        PAD: begin
          if (last_q) begin
            if (xfer) begin
              byte_valid_q <= 1'b0;
              last_q       <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= DONE;
            end
          end else if (out_free) begin
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b1;
            if (pad_q == PAD_LAST) begin
              pad_q <= '0;
              if (!row_last) begin
                row_q   <= row_q + 1'b1;
                state_q <= LOAD;
              end else begin
                last_q <= 1'b1;
              end
            end else begin
              pad_q <= pad_q + 2'd1;
            end
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Directed bench for bmp_stream_writer at WIDTH=3, HEIGHT=2 (three pad bytes per row).
// Expected header bytes are used only when BMP_HEADER_GEN_EN is defined.
module tb_bmp_stream_writer;

  localparam int W = 3;
  localparam int H = 2;
`ifdef BMP_HEADER_GEN_EN
  localparam int HDR_LEN = 54;
`else
  localparam int HDR_LEN = 0;
`endif
  localparam int ROW_BYTES = 12;
  localparam int FRAME_LEN = HDR_LEN + ROW_BYTES * H;

  // File size 78 (0x4E), image size 24 (0x18), 2835 = 0x0B13.
  localparam logic [7:0] HDR_EXP [54] = '{
    8'h42, 8'h4D, 8'h4E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h36, 8'h00, 8'h00, 8'h00, 8'h28, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00,
    8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h18, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h18, 8'h00, 8'h00, 8'h00, 8'h13, 8'h0B,
    8'h00, 8'h00, 8'h13, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [23:0] PX_TAB [12] = '{
    24'hA1B2C3, 24'h102030, 24'h445566, 24'h778899, 24'hABCDEF, 24'h010203,
    24'hFEDCBA, 24'h0F1E2D, 24'h3C4B5A, 24'h697887, 24'h969594, 24'h00FF00
  };

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pix_empty;
  logic [23:0] pix_dout;
  logic        pix_rd_en;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic        busy;
  logic        done;

  always #5 clock = ~clock;

  bmp_stream_writer #(.WIDTH(W), .HEIGHT(H)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .pix_empty  (pix_empty),
    .pix_dout   (pix_dout),
    .pix_rd_en  (pix_rd_en),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done)
  );

  // First-word-fall-through FIFO model; the read pointer moves on the edge that sees pix_rd_en.
  logic [23:0] fifo_mem [64];
  int          wr_ptr   = 0;
  int          rd_ptr   = 0;
  logic        stall    = 1'b0;
  logic        fifo_clr = 1'b0;

  assign pix_empty = (rd_ptr == wr_ptr) || stall;
  assign pix_dout  = fifo_mem[rd_ptr % 64];

  always @(posedge clock) begin
    if (fifo_clr)       rd_ptr <= wr_ptr;
    else if (pix_rd_en) rd_ptr <= rd_ptr + 1;
  end

  // Output monitor: captured bytes, capture cycle, pop and done pulse counts.
  logic [7:0] rx     [1024];
  int         rx_cyc [1024];
  int         rx_cnt      = 0;
  int         rd_pulses   = 0;
  int         done_pulses = 0;
  int         cyc         = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (byte_valid && byte_ready) begin
      rx[rx_cnt]     <= byte_out;
      rx_cyc[rx_cnt] <= cyc;
      rx_cnt         <= rx_cnt + 1;
    end
    if (pix_rd_en) rd_pulses   <= rd_pulses + 1;
    if (done)      done_pulses <= done_pulses + 1;
  end

  // A byte offered but refused must reappear unchanged in the following cycle.
  logic       hold_pend = 1'b0;
  logic [7:0] hold_byte = 8'h00;
  int         hold_err  = 0;

  always @(posedge clock) begin
    if (hold_pend && (byte_valid !== 1'b1 || byte_out !== hold_byte)) hold_err <= hold_err + 1;
    hold_pend <= byte_valid && !byte_ready && reset;
    hold_byte <= byte_out;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_b [128];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue six pixels into the FIFO and build the byte stream they should produce.
  task automatic prep_frame(input int off);
    int n;
    logic [23:0] px;
    n = 0;
    for (int i = 0; i < HDR_LEN; i++) begin
      exp_b[n] = HDR_EXP[i];
      n = n + 1;
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        px = PX_TAB[off + r * W + c];
        fifo_mem[wr_ptr % 64] = px;
        wr_ptr = wr_ptr + 1;
        exp_b[n]     = px[23:16];
        exp_b[n + 1] = px[15:8];
        exp_b[n + 2] = px[7:0];
        n = n + 3;
      end
      for (int p = 0; p < 3; p++) begin
        exp_b[n] = 8'h00;
        n = n + 1;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Wait for done with a cycle budget; bp toggles byte_ready 1,0,0,1 and re-pulses start mid-frame.
  task automatic wait_done(input string tag, input bit bp);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 2000) begin
      @(negedge clock);
      if (bp) begin
        byte_ready = (k % 4 == 1 || k % 4 == 2) ? 1'b0 : 1'b1;
        start      = (k == 10);
      end
      k++;
    end
    check({tag, " done seen"}, {31'd0, done}, 32'd1);
    check({tag, " busy in done cycle"}, {31'd0, busy}, 32'd1);
    byte_ready = 1'b1;
    start      = 1'b0;
    @(negedge clock);
    check({tag, " busy after done"}, {31'd0, busy}, 32'd0);
    check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
  endtask

  task automatic wait_rx(input string tag, input int target);
    int k;
    k = 0;
    while (rx_cnt < target && k < 2000) begin
      @(negedge clock);
      k++;
    end
    check({tag, " reached byte count"}, {31'd0, rx_cnt >= target}, 32'd1);
  endtask

  task automatic cmp_frame(input string tag, input int base);
    check({tag, " length"}, rx_cnt - base, FRAME_LEN);
    for (int i = 0; i < FRAME_LEN; i++)
      check($sformatf("%s byte%0d", tag, i), {24'd0, rx[base + i]}, {24'd0, exp_b[i]});
  endtask

  initial begin
    int base;
    int rd0;
    int d0;
    int k;

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst byte_out", {24'd0, byte_out}, 32'h00);
    check("rst byte_valid", {31'd0, byte_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst pix_rd_en", {31'd0, pix_rd_en}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle busy", {31'd0, busy}, 32'd0);

    // Frame 1: full rate, ready held high.
    prep_frame(0);
    base = rx_cnt;
    rd0  = rd_pulses;
    d0   = done_pulses;
    pulse_start();
    wait_done("f1", 1'b0);
    cmp_frame("f1", base);
    check("f1 first pixel byte", {24'd0, rx[base + HDR_LEN]}, 32'hA1);
    check("f1 second pixel byte", {24'd0, rx[base + HDR_LEN + 1]}, 32'hB2);
    check("f1 third pixel byte", {24'd0, rx[base + HDR_LEN + 2]}, 32'hC3);
    check("f1 pops", rd_pulses - rd0, 32'd6);
    check("f1 done pulses", done_pulses - d0, 32'd1);
    check("f1 one byte per cycle", rx_cyc[base + FRAME_LEN - 1] - rx_cyc[base], FRAME_LEN - 1);

    // Frame 2: backpressure plus an ignored start while busy.
    prep_frame(6);
    base = rx_cnt;
    rd0  = rd_pulses;
    d0   = done_pulses;
    pulse_start();
    wait_done("f2", 1'b1);
    cmp_frame("f2", base);
    check("f2 pops", rd_pulses - rd0, 32'd6);
    check("f2 done pulses", done_pulses - d0, 32'd1);
    check("f2 held byte stable", hold_err, 32'd0);
    repeat (5) @(negedge clock);
    check("f2 no extra bytes", rx_cnt - base, FRAME_LEN);

    // Frame 3: FIFO empty mid-row for five cycles.
    prep_frame(0);
    base = rx_cnt;
    pulse_start();
    wait_rx("f3 stall point", base + HDR_LEN + 4);
    stall = 1'b1;
    k = 0;
    while (byte_valid !== 1'b0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("f3 stall valid c%0d", i), {31'd0, byte_valid}, 32'd0);
      check($sformatf("f3 stall rd_en c%0d", i), {31'd0, pix_rd_en}, 32'd0);
      @(negedge clock);
    end
    stall = 1'b0;
    wait_done("f3", 1'b0);
    cmp_frame("f3", base);

    // Frame 4: reset mid-frame, then a fresh frame from the first byte.
    prep_frame(6);
    base = rx_cnt;
    pulse_start();
    wait_rx("f4 reset point", base + ((HDR_LEN > 0) ? 60 : 15));
    reset = 1'b0;
    #1;
    check("mid rst byte_out", {24'd0, byte_out}, 32'h00);
    check("mid rst byte_valid", {31'd0, byte_valid}, 32'd0);
    check("mid rst busy", {31'd0, busy}, 32'd0);
    check("mid rst done", {31'd0, done}, 32'd0);
    check("mid rst pix_rd_en", {31'd0, pix_rd_en}, 32'd0);
    @(negedge clock);
    check("in rst pix_rd_en", {31'd0, pix_rd_en}, 32'd0);
    reset    = 1'b1;
    fifo_clr = 1'b1;
    @(negedge clock);
    fifo_clr = 1'b0;
    base = rx_cnt;
    repeat (4) @(negedge clock);
    check("no resume after reset", rx_cnt - base, 32'd0);
    check("idle after reset busy", {31'd0, busy}, 32'd0);

    prep_frame(0);
    base = rx_cnt;
    d0   = done_pulses;
    pulse_start();
    wait_done("f5", 1'b0);
    cmp_frame("f5", base);
    check("f5 done pulses", done_pulses - d0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
